// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decode handoff and redirect input.
// The master modport is the fetch unit; the slave modport is its environment.
interface instruction_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instruction, pc_out,
      input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instruction, pc_out,
      output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC sequencer, single-outstanding memory requester and FWFT prefetch FIFO.
// Optional IFETCH_JUMP_PREDECODE_EN follows j-type jumps directly from the fetched word.
module instruction_fetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                 clk,
   input logic                 rst,
   instruction_fetch_if.master bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] target_pc;
   logic        req_q;
   logic        valid_q;
   logic [31:0] head_word;
   logic [31:0] head_pc;

   logic [31:0] mem_word [DEPTH];
   logic [31:0] mem_pc   [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic [AW:0]   count;
   logic [AW:0]   count_next;

   logic        flush;
   logic        push;
   logic        pop;
   logic        room;
   logic [31:0] redir_pc;
   logic [31:0] pc_plus4;
   logic [31:0] next_seq_pc;
   logic [31:0] next_word;
   logic [31:0] next_pc;

   // Redirect beats any pop or push this cycle; a push lands in the slot reserved at issue time.
   always_comb begin
      flush    = bus.redirect_valid;
      push     = bus.imem_ack && (state == REQ) && !flush;
      pop      = valid_q && bus.instr_ready && !flush;
      redir_pc = bus.redirect_pc & ~32'd3;
      pc_plus4 = fetch_pc + 32'd4;
      rd_next  = pop ? rd_ptr + AW'(1) : rd_ptr;

      count_next = count;
      if (push && !pop) begin
         count_next = count + (AW+1)'(1);
      end else if (!push && pop) begin
         count_next = count - (AW+1)'(1);
      end
      room = count_next < (AW+1)'(DEPTH);

      // The new head comes straight from memory when the FIFO was about to go empty.
      if (push && (wr_ptr == rd_next)) begin
         next_word = bus.imem_rdata;
         next_pc   = fetch_pc;
      end else begin
         next_word = mem_word[rd_next];
         next_pc   = mem_pc[rd_next];
      end

`ifdef IFETCH_JUMP_PREDECODE_EN
      if (bus.imem_rdata[31:26] == 6'h02) begin
         next_seq_pc = {pc_plus4[31:28], bus.imem_rdata[25:0], 2'b00};
      end else begin
         next_seq_pc = pc_plus4;
      end
`else
      next_seq_pc = pc_plus4;
`endif
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_word[wr_ptr] <= bus.imem_rdata;
         mem_pc[wr_ptr]   <= fetch_pc;
      end
   end

   // Fetch FSM plus FIFO bookkeeping; head word/PC are registered and hold while empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         target_pc <= RESET_PC;
         req_q     <= 1'b0;
         valid_q   <= 1'b0;
         head_word <= 32'd0;
         head_pc   <= 32'd0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_next;
            count   <= count_next;
            valid_q <= (count_next != '0);
            if (count_next != '0) begin
               head_word <= next_word;
               head_pc   <= next_pc;
            end
         end

         case (state)
            IDLE: begin
               if (flush) begin
                  fetch_pc <= redir_pc;
                  state    <= REQ;
                  req_q    <= 1'b1;
               end else if (room) begin
                  state <= REQ;
                  req_q <= 1'b1;
               end
            end
            REQ: begin
               if (flush) begin
                  if (bus.imem_ack) begin
                     fetch_pc <= redir_pc;
                  end else begin
                     target_pc <= redir_pc;
                     state     <= DROP;
                  end
               end else if (bus.imem_ack) begin
                  fetch_pc <= next_seq_pc;
                  if (!room) begin
                     state <= IDLE;
                     req_q <= 1'b0;
                  end
               end
            end
            DROP: begin
               if (bus.imem_ack) begin
                  fetch_pc <= flush ? redir_pc : target_pc;
                  state    <= REQ;
               end else if (flush) begin
                  target_pc <= redir_pc;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = fetch_pc;
   assign bus.instr_valid = valid_q;
   assign bus.instruction = head_word;
   assign bus.pc_out      = head_pc;
endmodule
